// File: rtl/cpu_pkg.sv
// cpu_pkg: shared states, opcodes, widths and BTRU target table
package cpu_pkg;
  localparam int PW_DEF = 10;
  localparam int IW_DEF = 9;
  localparam logic [3:0] OP_BTRU = 4'd11;
  localparam logic [3:0] OP_HALT = 4'd15;
  localparam logic [2:0] IOP_B = 3'd3;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;
  localparam logic [15:0] BTRU_TARGETS [16] = '{
    16'd0, 16'd37, 16'd100, 16'd200, 16'd300, 16'd400, 16'd511, 16'd512,
    16'd600, 16'd700, 16'd800, 16'd900, 16'd1000, 16'd1020, 16'd1022, 16'd1023};
endpackage

// File: rtl/branch_lut.sv
// branch_lut: combinational ROM of BTRU jump targets
module branch_lut
  import cpu_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic [3:0]    idx,
  output logic [PW-1:0] tgt
);
  logic [15:0] entry;
  assign entry = BTRU_TARGETS[idx];
  assign tgt = entry[PW-1:0];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/exec/halt sequencer with registered decode and branch PC update
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          Start,
  output logic          IMemReq,
  output logic [PW-1:0] IMemAddr,
  input  logic          IMemValid,
  input  logic [IW-1:0] IMemData,
  output logic          Type,
  output logic [3:0]    RTypeOP,
  output logic [2:0]    ITypeOP,
  output logic [7:0]    ImmediateOut,
  output logic [3:0]    RegAddr,
  output logic          ExecValid,
  input  logic          Branch,
  output logic          Done
);
  state_e state_q, state_d;
  logic [PW-1:0] pc_q, pc_d, lut_tgt, b_off;
  logic [IW-1:0] ir_q, ir_d;
  logic type_q, type_d, ev_q, ev_d, load, halt_op, is_b, is_btru;
  logic [3:0] rop_q, rop_d, reg_q, reg_d;
  logic [2:0] iop_q, iop_d;
  logic [7:0] imm_q, imm_d;

  branch_lut #(.PW(PW)) u_lut (.idx(ir_q[3:0]), .tgt(lut_tgt));

  assign halt_op = ir_q[8] && ir_q[7:4] == OP_HALT;
  assign is_b = !ir_q[8] && ir_q[7:5] == IOP_B;
  assign is_btru = ir_q[8] && ir_q[7:4] == OP_BTRU;
  assign b_off = {{(PW-5){ir_q[4]}}, ir_q[4:0]};

  // next state, PC, IR and the decode of the instruction entering EXEC
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    load = 1'b0;
    type_d = 1'b0;
    rop_d = '0;
    iop_d = '0;
    imm_d = '0;
    reg_d = '0;
    ev_d = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: if (Start) begin
        pc_d = '0;
        state_d = S_FETCH;
      end
      S_FETCH: if (IMemValid) begin
        ir_d = IMemData;
        load = 1'b1;
        state_d = S_EXEC;
      end
      default: begin
        state_d = halt_op ? S_HALT : S_FETCH;
        pc_d = halt_op ? pc_q : (Branch && is_b) ? pc_q + b_off :
               (Branch && is_btru) ? lut_tgt : pc_q + 1'b1;
      end
    endcase
    if (load) begin
      type_d = ir_d[8];
      rop_d = ir_d[8] ? ir_d[7:4] : 4'd0;
      iop_d = ir_d[8] ? 3'd0 : ir_d[7:5];
      imm_d = ir_d[8] ? 8'd0 : {3'd0, ir_d[4:0]};
      reg_d = ir_d[8] ? ir_d[3:0] : 4'd0;
      ev_d = !(ir_d[8] && ir_d[7:4] == OP_HALT);
    end
  end

  // state, PC, IR and decoded output registers
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      ir_q <= '0;
      type_q <= 1'b0;
      rop_q <= '0;
      iop_q <= '0;
      imm_q <= '0;
      reg_q <= '0;
      ev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      type_q <= type_d;
      rop_q <= rop_d;
      iop_q <= iop_d;
      imm_q <= imm_d;
      reg_q <= reg_d;
      ev_q <= ev_d;
    end
  end

  assign IMemReq = state_q == S_FETCH;
  assign IMemAddr = pc_q;
  assign Done = state_q == S_HALT;
  assign Type = type_q;
  assign RTypeOP = rop_q;
  assign ITypeOP = iop_q;
  assign ImmediateOut = imm_q;
  assign RegAddr = reg_q;
  assign ExecValid = ev_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and random checks against an instruction-level model
module tb_instr_sequencer;
  import cpu_pkg::*;
  logic Clk = 0, ResetN, Start, IMemValid, Branch;
  logic IMemReq, Type, ExecValid, Done;
  logic [9:0] IMemAddr;
  logic [8:0] IMemData;
  logic [3:0] RTypeOP, RegAddr;
  logic [2:0] ITypeOP;
  logic [7:0] ImmediateOut;
  logic [8:0] mem [1024];
  int mp, n_vec, n_err;
  bit halted;

  instr_sequencer dut (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemValid(IMemValid), .IMemData(IMemData), .Type(Type), .RTypeOP(RTypeOP),
    .ITypeOP(ITypeOP), .ImmediateOut(ImmediateOut), .RegAddr(RegAddr),
    .ExecValid(ExecValid), .Branch(Branch), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ins_i(input int op3, input int imm5);
    return {1'b0, 3'(op3), 5'(imm5)};
  endfunction

  function automatic logic [8:0] ins_r(input int op4, input int reg4);
    return {1'b1, 4'(op4), 4'(reg4)};
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_req"}, IMemReq, 0);
    check({tag, "_addr"}, IMemAddr, 0);
    check({tag, "_ev"}, ExecValid, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_fields"}, {Type, RTypeOP, ITypeOP, ImmediateOut, RegAddr}, 0);
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    #2 ResetN = 0;
    #1 check_quiet("rst");
    @(negedge Clk);
    ResetN = 1;
    mp = 0;
    halted = 0;
  endtask

  task automatic start_prog();
    Start = 1;
    @(negedge Clk);
    Start = 0;
    mp = 0;
    halted = 0;
  endtask

  task automatic exec_one(input int w, input logic br);
    logic [8:0] ins;
    int off;
    bit r;
    ins = mem[mp];
    r = ins[8];
    for (int i = 0; i < w; i++) begin
      IMemValid = 0;
      Start = 1'($urandom_range(0, 1));
      check("wait_req", IMemReq, 1);
      check("wait_addr", IMemAddr, mp);
      @(negedge Clk);
    end
    Start = 0;
    check("fetch_req", IMemReq, 1);
    check("fetch_addr", IMemAddr, mp);
    check("fetch_ev", ExecValid, 0);
    IMemValid = 1;
    IMemData = ins;
    @(negedge Clk);
    IMemValid = 1'($urandom_range(0, 1));
    IMemData = 9'($urandom);
    Start = 1'($urandom_range(0, 1));
    Branch = br;
    halted = r && ins[7:4] == 15;
    check("exec_ev", ExecValid, !halted);
    check("exec_req", IMemReq, 0);
    check("exec_type", Type, r);
    check("exec_rop", RTypeOP, r ? ins[7:4] : 0);
    check("exec_iop", ITypeOP, r ? 0 : ins[7:5]);
    check("exec_imm", ImmediateOut, r ? 0 : ins[4:0]);
    check("exec_reg", RegAddr, r ? ins[3:0] : 0);
    off = ins[4:0] >= 16 ? int'(ins[4:0]) - 32 : int'(ins[4:0]);
    if (halted) mp = mp;
    else if (br && !r && ins[7:5] == 3) mp = (mp + off + 1024) % 1024;
    else if (br && r && ins[7:4] == 11) mp = int'(BTRU_TARGETS[ins[3:0]]) % 1024;
    else mp = (mp + 1) % 1024;
    @(negedge Clk);
    Branch = 0;
    Start = 0;
    IMemValid = 0;
    check("post_done", Done, halted);
    if (halted) begin
      check("halt_req", IMemReq, 0);
      check("halt_addr", IMemAddr, mp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    ResetN = 0;
    Start = 0;
    IMemValid = 0;
    IMemData = 0;
    Branch = 0;
    for (int i = 0; i < 1024; i++) mem[i] = ins_r(15, 0);
    #12 check_quiet("por");
    @(negedge Clk);
    ResetN = 1;
    mp = 0;
    // three ADDI then HALT, zero-wait memory
    for (int i = 0; i < 3; i++) mem[i] = ins_i(0, i + 1);
    mem[3] = ins_r(15, 0);
    start_prog();
    for (int i = 0; i < 3; i++) exec_one(0, 1'(i == 1));
    exec_one(0, 0);
    check("halt_flag", halted, 1);
    repeat (2) begin
      @(negedge Clk);
      check("halt_hold", Done, 1);
      check("halt_addr3", IMemAddr, 3);
    end
    // delayed memory response at PC 0
    mem[0] = ins_i(0, 7);
    mem[1] = ins_r(15, 0);
    start_prog();
    exec_one(4, 0);
    check("slow_next", IMemAddr, 1);
    exec_one(0, 0);
    // B backwards taken / not taken at PC 5
    mem[0] = ins_i(3, 5);
    mem[5] = ins_i(3, 5'b11110);
    mem[3] = ins_r(15, 0);
    mem[6] = ins_r(15, 0);
    start_prog();
    exec_one(0, 1);
    check("b_to5", IMemAddr, 5);
    exec_one(0, 1);
    check("b_back", IMemAddr, 3);
    exec_one(0, 0);
    start_prog();
    exec_one(0, 1);
    exec_one(0, 0);
    check("b_nt", IMemAddr, 6);
    exec_one(0, 0);
    // BTRU via table and ignored Branch on ADD
    mem[0] = ins_r(11, 2);
    mem[100] = ins_r(15, 0);
    start_prog();
    exec_one(0, 1);
    check("btru", IMemAddr, 100);
    exec_one(0, 0);
    mem[0] = ins_i(3, 7);
    mem[7] = ins_r(0, 3);
    mem[8] = ins_r(15, 0);
    start_prog();
    exec_one(0, 1);
    exec_one(0, 1);
    check("add_br", IMemAddr, 8);
    exec_one(0, 0);
    // PC wrap and B wrap
    mem[0] = ins_r(11, 15);
    mem[1023] = ins_r(2, 1);
    start_prog();
    exec_one(0, 1);
    check("to1023", IMemAddr, 1023);
    exec_one(0, 1);
    check("wrap", IMemAddr, 0);
    apply_reset();
    mem[0] = ins_r(11, 13);
    mem[1020] = ins_i(3, 15);
    mem[11] = ins_r(15, 0);
    start_prog();
    exec_one(0, 1);
    exec_one(0, 1);
    check("b_wrap", IMemAddr, 11);
    exec_one(0, 0);
    // reset during fetch wait and during exec
    mem[0] = ins_i(3, 5);
    mem[1] = ins_r(5, 9);
    start_prog();
    exec_one(0, 1);
    IMemValid = 0;
    @(negedge Clk);
    check("fw_req", IMemReq, 1);
    apply_reset();
    check("after_rst_req", IMemReq, 0);
    start_prog();
    exec_one(0, 0);
    check("rst_pc1", IMemAddr, 1);
    IMemValid = 1;
    IMemData = mem[1];
    @(negedge Clk);
    IMemValid = 0;
    check("pre_rst_ev", ExecValid, 1);
    #2 ResetN = 0;
    #1 check_quiet("rst_exec");
    @(negedge Clk);
    ResetN = 1;
    check("idle_addr", IMemAddr, 0);
    // random programs
    for (int i = 0; i < 1024; i++) begin
      int k;
      k = $urandom_range(0, 19);
      mem[i] = 9'($urandom);
      if (mem[i] == ins_r(15, int'(mem[i][3:0]))) mem[i] = ins_r(1, 0);
      if (k == 0) mem[i] = ins_r(15, 0);
      else if (k < 5) mem[i] = ins_i(3, int'($urandom_range(0, 31)));
      else if (k < 8) mem[i] = ins_r(11, int'($urandom_range(0, 15)));
    end
    mp = 0;
    halted = 1;
    for (int n = 0; n < 400; n++) begin
      if (halted) start_prog();
      exec_one(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
